regfile_wb_sequencer: RTL and testbench

- Initiator for the register file's write port. Accepts writeback requests from the execute/memory stages into a small in-order queue and drains them one per cycle onto the register file's WE/WrReg/InData inputs.
- After reset it sweeps zeros into every register, so the file never holds undefined values.
- Provides a forwarding lookup so read-side logic sees writes that are still pending.

---
 rtl/regfile_wb_sequencer.sv | 153 +++++++++++++++
 tb/tb_regfile_wb_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sequencer.sv
// Write-port sequencer for the register file: zero-sweeps every register after reset,
// then drains an in-order writeback queue one entry per cycle with forwarding lookup.
module regfile_wb_sequencer #(
   parameter int DEPTH    = 4,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wb_valid,
   input  logic [ADDR_W-1:0]          wb_reg,
   input  logic [DATA_W-1:0]          wb_data,
   output logic                       wb_ready,
   output logic                       WE,
   output logic [ADDR_W-1:0]          WrReg,
   output logic [DATA_W-1:0]          InData,
   output logic                       init_done,
   output logic [$clog2(DEPTH):0]     count,
   input  logic [ADDR_W-1:0]          ReadA,
   input  logic [ADDR_W-1:0]          ReadB,
   output logic                       fwd_hitA,
   output logic                       fwd_hitB,
   output logic [DATA_W-1:0]          fwd_dataA,
   output logic [DATA_W-1:0]          fwd_dataB
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [0:0] {INIT, RUN} state_t;

   state_t state, nextState;

   logic [ADDR_W-1:0] sweepIdx;
   logic [ADDR_W-1:0] regMem  [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [PW-1:0]     head, tail;
   logic              push, pop, sweepLast;
   logic [PW-1:0]     slot;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= INIT;
      else       state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         INIT:    if (sweepIdx == LAST_REG) nextState = RUN;
         RUN:     nextState = RUN;
         default: nextState = INIT;
      endcase
   end

   // Output / control decode
   always_comb begin
      wb_ready  = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      sweepLast = 1'b0;
      case (state)
         INIT: sweepLast = (sweepIdx == LAST_REG);
         RUN: begin
            wb_ready = (count < CW'(DEPTH));
            push     = wb_valid && wb_ready && (wb_reg != '0);
            pop      = (count != '0);
         end
         default: ;
      endcase
   end

   // Registered write-port outputs and sweep index
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         WE        <= 1'b0;
         WrReg     <= '0;
         InData    <= '0;
         init_done <= 1'b0;
         sweepIdx  <= '0;
      end else if (state == INIT) begin
         WE       <= 1'b1;
         WrReg    <= sweepIdx;
         InData   <= '0;
         sweepIdx <= sweepIdx + 1'b1;
         if (sweepLast) init_done <= 1'b1;
      end else if (pop) begin
         WE     <= 1'b1;
         WrReg  <= regMem[head];
         InData <= dataMem[head];
      end else begin
         WE <= 1'b0;
      end
   end

   // Queue pointers and occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Entry storage needs no reset; occupancy decides which slots are live
   always_ff @(posedge clock) begin
      if (push) begin
         regMem[tail]  <= wb_reg;
         dataMem[tail] <= wb_data;
      end
   end

   // Forwarding: scan WE entry first, then head..tail so younger matches overwrite
   always_comb begin
      fwd_hitA  = 1'b0;
      fwd_hitB  = 1'b0;
      fwd_dataA = '0;
      fwd_dataB = '0;
      slot      = head;
      if (state == RUN) begin
         if (WE && (WrReg == ReadA) && (ReadA != '0)) begin
            fwd_hitA  = 1'b1;
            fwd_dataA = InData;
         end
         if (WE && (WrReg == ReadB) && (ReadB != '0)) begin
            fwd_hitB  = 1'b1;
            fwd_dataB = InData;
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(count)) begin
               slot = head + PW'(i);
               if ((regMem[slot] == ReadA) && (ReadA != '0)) begin
                  fwd_hitA  = 1'b1;
                  fwd_dataA = dataMem[slot];
               end
               if ((regMem[slot] == ReadB) && (ReadB != '0)) begin
                  fwd_hitB  = 1'b1;
                  fwd_dataB = dataMem[slot];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed bench for regfile_wb_sequencer: init sweep, drain latency, FIFO order,
// r0 discard, forwarding priority and mid-traffic reset.
module tb_regfile_wb_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
   logic        wb_ready;
   logic        WE;
   logic [4:0]  WrReg;
   logic [31:0] InData;
   logic        init_done;
   logic [2:0]  count;
   logic [4:0]  ReadA = 5'd5;
   logic [4:0]  ReadB = 5'd3;
   logic        fwd_hitA, fwd_hitB;
   logic [31:0] fwd_dataA, fwd_dataB;

   int checks = 0;
   int errors = 0;

   regfile_wb_sequencer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clock(clock), .reset(reset),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
      .WE(WE), .WrReg(WrReg), .InData(InData), .init_done(init_done), .count(count),
      .ReadA(ReadA), .ReadB(ReadB),
      .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB), .fwd_dataA(fwd_dataA), .fwd_dataB(fwd_dataB)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sweepCheck(input string tag);
      for (int i = 0; i < 32; i++) begin
         step();
         check({tag, "_we"}, 32'(WE), 32'd1);
         check({tag, "_wrreg"}, 32'(WrReg), 32'(i));
         check({tag, "_indata"}, InData, 32'd0);
         check({tag, "_initdone"}, 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
         check({tag, "_ready"}, 32'(wb_ready), (i == 31) ? 32'd1 : 32'd0);
         check({tag, "_nohitA"}, 32'(fwd_hitA), 32'd0);
      end
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_we", 32'(WE), 32'd0);
      check("rst_wrreg", 32'(WrReg), 32'd0);
      check("rst_indata", InData, 32'd0);
      check("rst_initdone", 32'(init_done), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_ready", 32'(wb_ready), 32'd0);
      step();
      step();
      reset = 1'b0;

      sweepCheck("sweep1");
      step();
      check("idle_we", 32'(WE), 32'd0);
      check("idle_initdone", 32'(init_done), 32'd1);
      check("idle_count", 32'(count), 32'd0);

      // Single write r3=0xAA
      wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h0000_00AA;
      #1;
      check("single_ready", 32'(wb_ready), 32'd1);
      step();
      wb_valid = 1'b0;
      #1;
      check("single_k_we", 32'(WE), 32'd0);
      check("single_k_count", 32'(count), 32'd1);
      check("single_k_hitB", 32'(fwd_hitB), 32'd1);
      check("single_k_dataB", fwd_dataB, 32'h0000_00AA);
      step();
      check("single_k1_we", 32'(WE), 32'd1);
      check("single_k1_wrreg", 32'(WrReg), 32'd3);
      check("single_k1_indata", InData, 32'h0000_00AA);
      check("single_k1_count", 32'(count), 32'd0);
      check("single_k1_hitB", 32'(fwd_hitB), 32'd1);
      step();
      check("single_k2_we", 32'(WE), 32'd0);
      check("single_k2_wrreg_hold", 32'(WrReg), 32'd3);
      check("single_k2_indata_hold", InData, 32'h0000_00AA);
      check("single_k2_hitB", 32'(fwd_hitB), 32'd0);
      check("single_k2_dataB", fwd_dataB, 32'd0);

      // Five back-to-back writes r6..r10 drain in order, one per cycle
      for (int i = 0; i < 5; i++) begin
         wb_valid = 1'b1; wb_reg = 5'(6 + i); wb_data = 32'h100 + 32'(i);
         #1;
         check("burst_ready", 32'(wb_ready), 32'd1);
         step();
         check("burst_count", 32'(count), 32'd1);
         check("burst_we", 32'(WE), (i == 0) ? 32'd0 : 32'd1);
         if (i != 0) begin
            check("burst_wrreg", 32'(WrReg), 32'(5 + i));
            check("burst_indata", InData, 32'h100 + 32'(i - 1));
         end
      end
      wb_valid = 1'b0;
      step();
      check("burst_last_we", 32'(WE), 32'd1);
      check("burst_last_wrreg", 32'(WrReg), 32'd10);
      check("burst_last_indata", InData, 32'h104);
      check("burst_last_count", 32'(count), 32'd0);
      step();
      check("burst_end_we", 32'(WE), 32'd0);

      // r0 write is accepted and discarded
      ReadA = 5'd0;
      wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
      #1;
      check("r0_ready", 32'(wb_ready), 32'd1);
      step();
      wb_valid = 1'b0;
      check("r0_count", 32'(count), 32'd0);
      check("r0_we", 32'(WE), 32'd0);
      check("r0_hitA", 32'(fwd_hitA), 32'd0);
      step();
      check("r0_we2", 32'(WE), 32'd0);
      check("r0_indata_hold", InData, 32'h104);

      // r5=0x11 then r5=0x22, youngest value forwarded
      ReadA = 5'd5;
      wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h11;
      step();
      check("fwd1_hitA", 32'(fwd_hitA), 32'd1);
      check("fwd1_dataA", fwd_dataA, 32'h11);
      wb_data = 32'h22;
      step();
      wb_valid = 1'b0;
      check("fwd2_we", 32'(WE), 32'd1);
      check("fwd2_indata", InData, 32'h11);
      check("fwd2_hitA", 32'(fwd_hitA), 32'd1);
      check("fwd2_dataA", fwd_dataA, 32'h22);
      step();
      check("fwd3_indata", InData, 32'h22);
      check("fwd3_dataA", fwd_dataA, 32'h22);
      step();
      check("fwd4_hitA", 32'(fwd_hitA), 32'd0);
      check("fwd4_dataA", fwd_dataA, 32'd0);

      // Writes in flight, then a reset pulse drops them and restarts the sweep
      ReadA = 5'd8;
      wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'h71;
      step();
      wb_reg = 5'd8; wb_data = 32'h81;
      step();
      wb_reg = 5'd9; wb_data = 32'h91;
      step();
      wb_valid = 1'b0;
      check("pre_rst_wrreg", 32'(WrReg), 32'd8);
      check("pre_rst_count", 32'(count), 32'd1);
      check("pre_rst_dataA", fwd_dataA, 32'h81);
      reset = 1'b1;
      #1;
      check("midrst_we", 32'(WE), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_initdone", 32'(init_done), 32'd0);
      check("midrst_hitA", 32'(fwd_hitA), 32'd0);
      step();
      reset = 1'b0;
      sweepCheck("sweep2");
      step();
      check("post_we", 32'(WE), 32'd0);
      check("post_count", 32'(count), 32'd0);
      check("post_wrreg_hold", 32'(WrReg), 32'd31);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
